// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: datapath widths, op encodings and pipeline register bundles.
package cpu_defs_pkg;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned RW = 3;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_ALU   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_STORE = 2'b11
  } op_e;

  typedef struct packed {
    logic          valid;
    op_e           op;
    logic [DW-1:0] result;
    logic [DW-1:0] sdata;
    logic [RW-1:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic          we;
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } mem_wb_t;

  // True when an effective address reaches beyond the data memory.
  function automatic logic addr_oob(input logic [DW-1:0] addr);
    return addr[DW-1:AW] != '0;
  endfunction

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt16
  import cpu_defs_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: EX/MEM register, data memory drive, forwarding bus,
// MEM/WB register, op counters and sticky out-of-range address flag.
module mem_stage
  import cpu_defs_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic [1:0]    ex_op,
  input  logic [DW-1:0] ex_result,
  input  logic [DW-1:0] ex_sdata,
  input  logic [RW-1:0] ex_rd,
  input  logic          stall,
  input  logic          flush,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  output logic          dm_dwe,
  input  logic [DW-1:0] dm_rdata,
  output logic          fwd_we,
  output logic [RW-1:0] fwd_rd,
  output logic [DW-1:0] fwd_data,
  output logic          wb_we,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic [CW-1:0] ld_cnt,
  output logic [CW-1:0] st_cnt,
  output logic [CW-1:0] bub_cnt,
  output logic          err_addr
);

  ex_mem_t em_q, em_d;
  mem_wb_t wb_q, wb_d;
  logic    err_q;

  logic is_load, is_store, is_alu, mem_access;
  logic ld_en, bub_en;

  assign is_load    = em_q.valid && (em_q.op == OP_LOAD);
  assign is_store   = em_q.valid && (em_q.op == OP_STORE);
  assign is_alu     = em_q.valid && (em_q.op == OP_ALU);
  assign mem_access = is_load || is_store;

  // EX/MEM next value: stall holds, flush inserts a bubble, else capture EX.
  always_comb begin
    em_d = em_q;
    if (!stall) begin
      if (flush) begin
        em_d = '0;
      end else begin
        em_d.valid  = ex_valid;
        em_d.op     = op_e'(ex_op);
        em_d.result = ex_result;
        em_d.sdata  = ex_sdata;
        em_d.rd     = ex_rd;
      end
    end
  end

  // Memory port; the write is gated so it lands only on an advancing edge.
  assign dm_addr  = em_q.result[AW-1:0];
  assign dm_wdata = em_q.sdata;
  assign dm_dwe   = is_store && !stall && !rst;

  assign fwd_we   = (is_alu || is_load) && (em_q.rd != '0);
  assign fwd_rd   = em_q.rd;
  assign fwd_data = is_load ? dm_rdata : em_q.result;

  always_comb begin
    wb_d = wb_q;
    if (!stall) begin
      wb_d.we   = fwd_we;
      wb_d.rd   = em_q.rd;
      wb_d.data = fwd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      em_q  <= '0;
      wb_q  <= '0;
      err_q <= 1'b0;
    end else begin
      em_q <= em_d;
      wb_q <= wb_d;
      if (!stall && mem_access && addr_oob(em_q.result)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign wb_we    = wb_q.we;
  assign wb_rd    = wb_q.rd;
  assign wb_data  = wb_q.data;
  assign err_addr = err_q;

  // A bubble is anything entering MEM that is not a real instruction.
  assign ld_en  = is_load && !stall;
  assign bub_en = !stall && (flush || !ex_valid || (ex_op == 2'(OP_NOP)));

  sat_cnt16 u_ld_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (ld_en),
    .count (ld_cnt)
  );

  sat_cnt16 u_st_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (dm_dwe),
    .count (st_cnt)
  );

  sat_cnt16 u_bub_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (bub_en),
    .count (bub_cnt)
  );

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 16-bit pipeline CPU.
- Holds the EX/MEM pipeline register and drives the data memory port (addr, dwe, wdata, combinational rdata).
- Selects the load or ALU result and holds the MEM/WB register that feeds writeback.
- Also provides the MEM-stage forwarding bus, stall/flush bubble handling, per-op counters and a sticky address-range error flag.

Parameters:
- DW, 16, datapath width.
- AW, 8, data memory address width (256 words).
- RW, 3, register index width; r0 is hardwired zero.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_op  in  2  00 NOP, 01 ALU, 10 LOAD, 11 STORE.
- ex_result  in  DW  ALU result, or effective address for LOAD/STORE.
- ex_sdata  in  DW  store data.
- ex_rd  in  RW  destination register.
- stall  in  1  freeze both pipeline registers.
- flush  in  1  discard the incoming EX instruction (insert bubble).
- dm_addr  out  AW  data memory address.
- dm_wdata  out  DW  data memory write data.
- dm_dwe  out  1  data memory write enable.
- dm_rdata  in  DW  data memory read data (combinational).
- fwd_we  out  1  MEM-stage forward valid.
- fwd_rd  out  RW  MEM-stage forward register.
- fwd_data  out  DW  MEM-stage forward value.
- wb_we  out  1  writeback enable.
- wb_rd  out  RW  writeback register.
- wb_data  out  DW  writeback value.
- ld_cnt  out  16  loads committed.
- st_cnt  out  16  stores committed.
- bub_cnt  out  16  bubbles entering MEM.
- err_addr  out  1  sticky: a LOAD/STORE address had bits [DW-1:AW] nonzero.

Behaviour:
- Reset, synchronous, while rst=1 at the edge:
  - EX/MEM cleared: valid=0, op=NOP, fields=0.
  - MEM/WB cleared: wb_we=0, wb_rd=0, wb_data=0.
  - Counters = 0; err_addr = 0.
  - Reset mid-operation discards in-flight ops; no write occurs in the reset cycle (dm_dwe gated by !rst).
- EX/MEM update priority: rst > stall (hold everything) > flush (capture bubble: valid=0, op=NOP) > normal (capture ex_* with valid=ex_valid).
  - flush while stall is ignored; upstream holds flush until stall drops.
- Memory drive (combinational from EX/MEM):
  - dm_addr = result[AW-1:0], upper bits ignored.
  - dm_wdata = sdata.
  - dm_dwe = valid & op==STORE & !stall & !rst.
  - Each store commits exactly once, on the edge where the stage advances.
  - A load in the cycle after a store to the same address sees new data; no internal forwarding is needed.
- Forward bus:
  - fwd_we = valid & (ALU|LOAD) & rd!=0.
  - fwd_data = LOAD ? dm_rdata : result.
  - fwd_rd = rd.
- MEM/WB: hold on stall; otherwise capture:
  - wb_we = fwd_we.
  - wb_rd = rd.
  - wb_data = fwd_data.
  - STORE/NOP/bubble give wb_we=0.
  - Latency: EX-stage capture edge to wb_* valid is exactly 2 edges with no stall.
- Counters advance only on non-stall, non-reset edges and saturate at 0xFFFF (no wrap):
  - ld_cnt +1 when a valid LOAD leaves MEM.
  - st_cnt +1 when dm_dwe=1.
  - bub_cnt +1 when EX/MEM captures valid=0 (flush, ex_valid=0, or ex_op=NOP).
- err_addr:
  - Set when a valid LOAD/STORE is in EX/MEM with result[DW-1:AW]!=0 on an advancing edge.
  - The access still proceeds on the truncated address.
  - Cleared only by rst.

Decomposition:
- Shared package/header cpu_defs:
  - op encodings OP_NOP/OP_ALU/OP_LOAD/OP_STORE.
  - DW/AW/RW defaults.
  - the EX/MEM and MEM/WB bundle typedefs.
- Optional sub-module sat_cnt16 (enable, rst, saturating 16-bit count), instantiated three times.
- Memory itself stays external.

Test Plan:
- rst=1 two cycles with ex_valid=1 STORE addr 0x0003 -> dm_dwe never 1, all outputs and counters 0. Then release: data memory word 3 still 0x2369.
- STORE addr 0x0005 data 0xBEEF, then LOAD addr 0x0005 rd=2 back-to-back:
  - dm_dwe=1 for exactly one cycle.
  - two edges after the load enters, wb_we=1, wb_rd=2, wb_data=0xBEEF; st_cnt=1, ld_cnt=1.
- STORE addr 0x0007 data 0x1234 held in EX/MEM with stall=1 for 3 cycles:
  - dm_dwe=0 during the stall, 1 on the release cycle only.
  - st_cnt=1; MEM/WB outputs unchanged during the stall.
- ALU result 0x00AA rd=0, then ALU 0x0055 rd=4:
  - first gives fwd_we=0, wb_we=0.
  - second gives fwd_we=1, fwd_data=0x0055, then wb_data=0x0055.
- flush=1 on an incoming STORE, and flush+stall together:
  - flush alone: bubble captured, no write, bub_cnt+1.
  - flush+stall: register held, bub_cnt unchanged.
- LOAD addr 0x0103 -> dm_addr=0x03, err_addr=1 and remains 1 after further legal ops until rst. Then force bub_cnt near 0xFFFF with idle cycles -> it sticks at 0xFFFF.
